// File: rtl/ub_pkg.sv
// Shared definitions for the banked 2-D buffer.
//   COORD_W  : coordinate width used on every x/y port
//   coord_t  : coordinate type
//   ub_err_t : sticky error flags (read bank conflict, out-of-range access)
//   ub_bank  : coordinate -> bank index (cyclic banking in x and y)
//   ub_addr  : coordinate -> word address inside its bank
//   ub_in_range : coordinate lies inside the logical image
package ub_pkg;

  localparam int unsigned COORD_W = 16;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    logic conflict;
    logic oob;
  } ub_err_t;

  // Bank factors are powers of two, so mod is a mask and the multiply is a shift.
  function automatic int unsigned ub_bank(input coord_t x, input coord_t y,
                                          input int unsigned bank_x,
                                          input int unsigned bank_y);
    int unsigned xm;
    int unsigned ym;
    xm = 32'(x) & (bank_x - 1);
    ym = 32'(y) & (bank_y - 1);
    return xm | (ym << $clog2(bank_x));
  endfunction

  // x/BANK_X and y/BANK_Y are the upper coordinate bits; the row stride
  // EXT_X/BANK_X is a power of two, so the address is a bit concatenation.
  function automatic int unsigned ub_addr(input coord_t x, input coord_t y,
                                          input int unsigned bank_x,
                                          input int unsigned bank_y,
                                          input int unsigned ext_x);
    int unsigned col;
    int unsigned row;
    col = 32'(x) >> $clog2(bank_x);
    row = 32'(y) >> $clog2(bank_y);
    return col | (row << ($clog2(ext_x) - $clog2(bank_x)));
  endfunction

  function automatic logic ub_in_range(input coord_t x, input coord_t y,
                                       input int unsigned ext_x,
                                       input int unsigned ext_y);
    return (32'(x) < ext_x) && (32'(y) < ext_y);
  endfunction

endpackage

// File: rtl/ub_bank_1r1w.sv
// One memory bank: a single write port and a single registered read port.
//   clk          : clock, rising edge
//   we/waddr/wdata : write strobe, address, data
//   re/raddr     : read strobe and address
//   rdata        : read data, updated on the edge after re, held otherwise
// A simultaneous read and write of the same address returns the old word.
module ub_bank_1r1w #(
  parameter int unsigned depth = 1024,
  parameter int unsigned width = 16,
  localparam int unsigned AW = (depth > 1) ? $clog2(depth) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [width-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [width-1:0] rdata
);

  logic [width-1:0] mem [depth];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ub_banked_2d.sv
// Cyclically banked 2-D buffer: one write port, NRD read ports, latency 1.
//   clk, rst_n     : clock (rising edge), asynchronous active-low reset
//   flush          : synchronous clear of read valids, error flags, wr_count
//   wr_en/wr_x/wr_y/wr_data : write strobe, coordinate, data
//   rd_en/rd_x/rd_y : per-port read strobe and coordinate
//   rd_data/rd_valid : per-port read data and qualifier (data held when invalid)
//   conflict_err   : sticky, two enabled reads hit one bank at different words
//   oob_err        : sticky, an access fell outside the image
//   wr_count       : committed writes, saturating at 0xFFFF
module ub_banked_2d
  import ub_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned EXT_X  = 64,
  parameter int unsigned EXT_Y  = 64,
  parameter int unsigned BANK_X = 2,
  parameter int unsigned BANK_Y = 2,
  parameter int unsigned NRD    = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          wr_en,
  input  logic [COORD_W-1:0]            wr_x,
  input  logic [COORD_W-1:0]            wr_y,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic [NRD-1:0]                rd_en,
  input  logic [NRD-1:0][COORD_W-1:0]   rd_x,
  input  logic [NRD-1:0][COORD_W-1:0]   rd_y,
  output logic [NRD-1:0][DATA_W-1:0]    rd_data,
  output logic [NRD-1:0]                rd_valid,
  output logic                          conflict_err,
  output logic                          oob_err,
  output logic [15:0]                   wr_count
);

  localparam int unsigned NB    = BANK_X * BANK_Y;
  localparam int unsigned DEPTH = (EXT_X * EXT_Y) / NB;
  localparam int unsigned BW    = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // write side
  logic          wr_ok;
  logic          wr_commit;
  logic [BW-1:0] wr_bank;
  logic [AW-1:0] wr_addr;

  assign wr_ok     = ub_in_range(wr_x, wr_y, EXT_X, EXT_Y);
  assign wr_commit = wr_en && wr_ok;
  assign wr_bank   = BW'(ub_bank(wr_x, wr_y, BANK_X, BANK_Y));
  assign wr_addr   = AW'(ub_addr(wr_x, wr_y, BANK_X, BANK_Y, EXT_X));

  // read side decode
  logic [NRD-1:0]         rd_ok;
  logic [NRD-1:0]         rd_req;
  logic [NRD-1:0][BW-1:0] rd_bank;
  logic [NRD-1:0][AW-1:0] rd_addr;

  always_comb begin
    rd_ok   = '0;
    rd_req  = '0;
    rd_bank = '0;
    rd_addr = '0;
    for (int unsigned p = 0; p < NRD; p++) begin
      rd_ok[p]   = ub_in_range(rd_x[p], rd_y[p], EXT_X, EXT_Y);
      rd_req[p]  = rd_en[p] && rd_ok[p];
      rd_bank[p] = BW'(ub_bank(rd_x[p], rd_y[p], BANK_X, BANK_Y));
      rd_addr[p] = AW'(ub_addr(rd_x[p], rd_y[p], BANK_X, BANK_Y, EXT_X));
    end
  end

  // Per-bank arbitration: the lowest-index requester claims the bank's read
  // address; later requesters for the same word share the result, any other
  // word on that bank is refused and flagged as a conflict.
  logic [NB-1:0]          bank_re;
  logic [AW-1:0]          bank_raddr [NB];
  logic [DATA_W-1:0]      bank_rdata [NB];
  logic [NB-1:0]          bank_we;
  logic [NRD-1:0]         served;
  logic                   conflict;

  always_comb begin
    bank_re  = '0;
    served   = '0;
    conflict = 1'b0;
    for (int unsigned b = 0; b < NB; b++) bank_raddr[b] = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      for (int unsigned p = 0; p < NRD; p++) begin
        if (rd_req[p] && (rd_bank[p] == BW'(b))) begin
          if (!bank_re[b]) begin
            bank_re[b]    = 1'b1;
            bank_raddr[b] = rd_addr[p];
            served[p]     = 1'b1;
          end else if (rd_addr[p] == bank_raddr[b]) begin
            served[p] = 1'b1;
          end else begin
            conflict = 1'b1;
          end
        end
      end
    end
  end

  for (genvar b = 0; b < NB; b++) begin : g_bank
    assign bank_we[b] = wr_commit && (wr_bank == BW'(b));

    ub_bank_1r1w #(
      .depth (DEPTH),
      .width (DATA_W)
    ) u_bank (
      .clk   (clk),
      .we    (bank_we[b]),
      .waddr (wr_addr),
      .wdata (wr_data),
      .re    (bank_re[b]),
      .raddr (bank_raddr[b]),
      .rdata (bank_rdata[b])
    );
  end

  // Output stage: the bank register supplies the one-cycle latency; hold_q
  // keeps the last presented word so a port's data stays put while invalid,
  // even if its bank is being read for another port.
  logic [NRD-1:0]              valid_q;
  logic [NRD-1:0][BW-1:0]      sel_q;
  logic [NRD-1:0][DATA_W-1:0]  hold_q;
  ub_err_t                     err_q;
  logic [15:0]                 count_q;
  logic                        oob_now;

  assign oob_now = (wr_en && !wr_ok) || (|(rd_en & ~rd_ok));

  always_comb begin
    rd_data = '0;
    for (int unsigned p = 0; p < NRD; p++) begin
      rd_data[p] = valid_q[p] ? bank_rdata[sel_q[p]] : hold_q[p];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      sel_q   <= '0;
      hold_q  <= '0;
      err_q   <= '0;
      count_q <= '0;
    end else begin
      hold_q <= rd_data;
      sel_q  <= rd_bank;
      if (flush) begin
        valid_q <= '0;
        err_q   <= '0;
        count_q <= '0;
      end else begin
        valid_q        <= served;
        err_q.conflict <= err_q.conflict | conflict;
        err_q.oob      <= err_q.oob | oob_now;
        if (wr_commit && (count_q != '1)) count_q <= count_q + 16'd1;
      end
    end
  end

  assign rd_valid     = valid_q;
  assign conflict_err = err_q.conflict;
  assign oob_err      = err_q.oob;
  assign wr_count     = count_q;

endmodule

// File: doc/ub_banked_2d.md
UB_BANKED_2D -- requirements
Module: ub_banked_2d

Interface
REQ-001 SHALL have parameter DATA_W, default 16: data word width.
REQ-002 SHALL have parameter EXT_X, default 64: logical image width; power of two.
REQ-003 SHALL have parameter EXT_Y, default 64: logical image height; power of two.
REQ-004 SHALL have parameter BANK_X, default 2: cyclic bank factor in x; power of two.
REQ-005 SHALL have parameter BANK_Y, default 2: cyclic bank factor in y; power of two.
REQ-006 SHALL have parameter NRD, default 2: number of read ports, 1..4.
REQ-007 SHALL have port clk, in, 1: clock, rising edge.
REQ-008 SHALL have port rst_n, in, 1: asynchronous, active-low reset.
REQ-009 SHALL have port flush, in, 1: synchronous clear of pipeline state and flags.
REQ-010 SHALL have ports wr_en (in, 1), wr_x (in, 16) and wr_y (in, 16): write strobe and coordinate.
REQ-011 SHALL have port wr_data, in, DATA_W: write data.
REQ-012 SHALL have ports rd_en (in, NRD), rd_x (in, NRD x 16) and rd_y (in, NRD x 16): per-port read strobe and coordinate.
REQ-013 SHALL have port rd_data, out, NRD x DATA_W: read data.
REQ-014 SHALL have port rd_valid, out, NRD: rd_data qualifier.
REQ-015 SHALL have port conflict_err, out, 1: sticky read bank-conflict flag.
REQ-016 SHALL have port oob_err, out, 1: sticky out-of-range access flag.
REQ-017 SHALL have port wr_count, out, 16: accepted writes, saturating.

Function
REQ-018 SHALL hold BANK_X*BANK_Y banks, each EXT_X*EXT_Y/(BANK_X*BANK_Y) words, with one write port and one read port per bank.
REQ-019 SHALL map a coordinate to bank = (x mod BANK_X) + BANK_X*(y mod BANK_Y); every bank is reachable (no aliasing to bank 0).
REQ-020 SHALL map a coordinate to address = (x / BANK_X) + (EXT_X/BANK_X)*(y / BANK_Y), using bit slices only (no dividers).
REQ-021 SHALL commit a write on the clk edge where wr_en=1 and x<EXT_X and y<EXT_Y.
REQ-022 SHALL drop an out-of-range write or read, and set oob_err.
REQ-023 SHALL give read latency 1: rd_data[p] and rd_valid[p] are registered on the edge after rd_en[p].
REQ-024 SHALL hold rd_data when the port's rd_valid=0.
REQ-025 SHALL return the pre-write word on read-during-write to the same bank and address (read-first).
REQ-026 SHALL serve both ports when two enabled read ports hit the same bank and the same address (broadcast).
REQ-027 SHALL, when enabled read ports hit the same bank at different addresses, serve the lowest-index port only, hold rd_valid=0 for the others next cycle, and set conflict_err.
REQ-028 SHALL increment wr_count per committed write, saturate at 0xFFFF, and never wrap.
REQ-029 SHALL, on flush=1, clear rd_valid, conflict_err, oob_err and wr_count at the next edge, with no effect on bank contents; a write in the same cycle still commits but is not counted.

Reset
REQ-030 SHALL, on rst_n low, asynchronously force rd_valid=0, rd_data=0, conflict_err=0, oob_err=0 and wr_count=0.
REQ-031 SHALL leave bank contents undefined after reset.
REQ-032 SHALL discard any read in flight when reset asserts mid-operation, with no rd_valid pulse after release.

Structure
REQ-033 SHALL place the coordinate width (16), the bank/address mapping functions and the error-flag type in a shared package ub_pkg.
REQ-034 SHALL implement each bank as sub-module ub_bank_1r1w (parameters depth and width, registered read), instantiated BANK_X*BANK_Y times via generate.

Verification
REQ-035 SHALL cover: write (x,y)=(0..63,0..63) with data=x+64y, then read all on port 0 -> each rd_data equals x+64y one cycle later; all four banks are hit.
REQ-036 SHALL cover: port 0 reads (2,0) and port 1 reads (4,0) in the same cycle -> port 0 valid, port 1 rd_valid=0, conflict_err=1.
REQ-037 SHALL cover: port 0 and port 1 both read (3,5) -> both valid with identical data, conflict_err stays 0.
REQ-038 SHALL cover: write 0xAAAA to (1,1), then write 0x5555 to (1,1) while reading (1,1) in the same cycle -> rd_data=0xAAAA; the next read returns 0x5555.
REQ-039 SHALL cover: write at (64,0) -> no commit, oob_err=1, wr_count unchanged; then flush -> oob_err=0 and wr_count=0.
REQ-040 SHALL cover: 65540 writes -> wr_count=0xFFFF; assert rst_n low mid-read -> rd_valid=0 immediately and all outputs zero.
